// File: rtl/prog_delay_timer.sv
// Programmable delay timer: counts a latched number of cycles after start
// and reports expiry as a held level, a single pulse or a periodic pulse.
module prog_delay_timer #(
    parameter int WIDTH = 8,
    parameter int EXP_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] load_val,
    input  logic [1:0]       mode,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] count,
    output logic [EXP_W-1:0] exp_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    localparam logic [1:0]       M_LEVEL    = 2'b00;
    localparam logic [1:0]       M_PERIODIC = 2'b10;
    localparam logic [WIDTH-1:0] CNT_ONE    = WIDTH'(1);
    localparam logic [EXP_W-1:0] EXP_ONE    = EXP_W'(1);

    state_e           state_q;
    logic [WIDTH-1:0] load_q;
    logic [1:0]       mode_q;
    logic [WIDTH-1:0] count_q;
    logic [EXP_W-1:0] exp_cnt_q;
    logic [EXP_W-1:0] exp_cnt_d;
    logic             busy_q;
    logic             done_q;
    logic             err_q;

    logic accept;
    logic reject;
    logic expire;

    // stop always wins, so a start alongside it is neither accepted nor rejected
    assign accept    = start && !stop && (load_val != '0);
    assign reject    = start && !stop && (load_val == '0);
    assign expire    = (count_q == load_q - CNT_ONE);
    assign exp_cnt_d = (&exp_cnt_q) ? exp_cnt_q : exp_cnt_q + EXP_ONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            load_q    <= '0;
            mode_q    <= 2'b00;
            count_q   <= '0;
            exp_cnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            err_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (accept) begin
                        load_q    <= load_val;
                        mode_q    <= mode;
                        count_q   <= '0;
                        exp_cnt_q <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= S_RUN;
                    end else if (reject) begin
                        err_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        count_q <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (expire) begin
                        count_q   <= '0;
                        exp_cnt_q <= exp_cnt_d;
                        done_q    <= 1'b1;
                        if (mode_q == M_LEVEL) begin
                            busy_q  <= 1'b0;
                            state_q <= S_DONE;
                        end else if (mode_q == M_PERIODIC) begin
                            busy_q  <= 1'b1;
                            state_q <= S_RUN;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end
                    end else begin
                        count_q <= count_q + CNT_ONE;
                        done_q  <= 1'b0;
                    end
                end
                S_DONE: begin
                    if (stop) begin
                        done_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (accept) begin
                        load_q    <= load_val;
                        mode_q    <= mode;
                        count_q   <= '0;
                        exp_cnt_q <= '0;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        state_q   <= S_RUN;
                    end else if (reject) begin
                        err_q <= 1'b1;
                    end
                end
                default: begin
                    count_q <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign count   = count_q;
    assign exp_cnt = exp_cnt_q;

endmodule

// File: tb/tb_prog_delay_timer.sv
// Directed bench for prog_delay_timer (WIDTH=8, EXP_W=2).
// Observed word is {busy, done, err, count[7:0], exp_cnt[1:0]}.
module tb_prog_delay_timer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic [7:0] load_val;
    logic [1:0] mode;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] count;
    logic [1:0] exp_cnt;

    int n_cmp;
    int n_bad;

    prog_delay_timer #(
        .WIDTH(8),
        .EXP_W(2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .load_val(load_val),
        .mode    (mode),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .count   (count),
        .exp_cnt (exp_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [12:0] snap();
        return {busy, done, err, count, exp_cnt};
    endfunction

    function automatic logic [12:0] exp_w(input logic b, input logic d,
                                          input logic e, input int c,
                                          input int x);
        return {b, d, e, 8'(c), 2'(x)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic kick(input logic [7:0] lv, input logic [1:0] md);
        load_val = lv;
        mode     = md;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic test_reset();
        logic [12:0] want;
        rst = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (snap() !== 13'd0) begin
            n_bad++;
            $display("FAIL reset_init: got %h want %h", snap(), 13'd0);
        end
        rst = 1'b0;
        kick(8'd2, 2'b00);
        tick();
        tick();
        want = exp_w(0, 1, 0, 0, 1);
        n_cmp++;
        if (snap() !== want) begin
            n_bad++;
            $display("FAIL reset_pre_done: got %h want %h", snap(), want);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (snap() !== 13'd0) begin
            n_bad++;
            $display("FAIL reset_async_done: got %h want %h", snap(), 13'd0);
        end
        tick();
        rst = 1'b0;
        kick(8'd10, 2'b01);
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (snap() !== 13'd0) begin
            n_bad++;
            $display("FAIL reset_async_run: got %h want %h", snap(), 13'd0);
        end
        tick();
        rst = 1'b0;
        kick(8'd2, 2'b01);
        tick();
        tick();
        want = exp_w(0, 1, 0, 0, 1);
        n_cmp++;
        if (snap() !== want) begin
            n_bad++;
            $display("FAIL reset_rerun: got %h want %h", snap(), want);
        end
        tick();
    endtask

    task automatic test_level();
        logic [12:0] want;
        kick(8'd5, 2'b00);
        for (int k = 0; k < 5; k++) begin
            want = exp_w(1, 0, 0, k, 0);
            n_cmp++;
            if (snap() !== want) begin
                n_bad++;
                $display("FAIL level_count%0d: got %h want %h", k, snap(), want);
            end
            tick();
        end
        for (int k = 0; k < 22; k++) begin
            want = exp_w(0, 1, 0, 0, 1);
            n_cmp++;
            if (snap() !== want) begin
                n_bad++;
                $display("FAIL level_hold%0d: got %h want %h", k, snap(), want);
            end
            tick();
        end
        kick(8'd3, 2'b00);
        for (int k = 0; k < 3; k++) begin
            want = exp_w(1, 0, 0, k, 0);
            n_cmp++;
            if (snap() !== want) begin
                n_bad++;
                $display("FAIL level_restart%0d: got %h want %h", k, snap(), want);
            end
            tick();
        end
        want = exp_w(0, 1, 0, 0, 1);
        n_cmp++;
        if (snap() !== want) begin
            n_bad++;
            $display("FAIL level_redone: got %h want %h", snap(), want);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        want = exp_w(0, 0, 0, 0, 1);
        n_cmp++;
        if (snap() !== want) begin
            n_bad++;
            $display("FAIL level_stop: got %h want %h", snap(), want);
        end
    endtask

    task automatic test_pulse();
        logic [12:0] want;
        kick(8'd1, 2'b01);
        want = exp_w(1, 0, 0, 0, 0);
        n_cmp++;
        if (snap() !== want) begin
            n_bad++;
            $display("FAIL pulse_e0: got %h want %h", snap(), want);
        end
        tick();
        want = exp_w(0, 1, 0, 0, 1);
        n_cmp++;
        if (snap() !== want) begin
            n_bad++;
            $display("FAIL pulse_e1: got %h want %h", snap(), want);
        end
        tick();
        want = exp_w(0, 0, 0, 0, 1);
        n_cmp++;
        if (snap() !== want) begin
            n_bad++;
            $display("FAIL pulse_after: got %h want %h", snap(), want);
        end
        kick(8'd2, 2'b11);
        tick();
        want = exp_w(1, 0, 0, 1, 0);
        n_cmp++;
        if (snap() !== want) begin
            n_bad++;
            $display("FAIL rsvd_e1: got %h want %h", snap(), want);
        end
        tick();
        want = exp_w(0, 1, 0, 0, 1);
        n_cmp++;
        if (snap() !== want) begin
            n_bad++;
            $display("FAIL rsvd_e2: got %h want %h", snap(), want);
        end
        tick();
        want = exp_w(0, 0, 0, 0, 1);
        n_cmp++;
        if (snap() !== want) begin
            n_bad++;
            $display("FAIL rsvd_after: got %h want %h", snap(), want);
        end
    endtask

    task automatic test_periodic();
        logic [12:0] want;
        kick(8'd4, 2'b10);
        for (int p = 1; p <= 4; p++) begin
            for (int c = 1; c <= 3; c++) begin
                tick();
                want = exp_w(1, 0, 0, c, (p - 1 > 3) ? 3 : p - 1);
                n_cmp++;
                if (snap() !== want) begin
                    n_bad++;
                    $display("FAIL periodic_p%0d_c%0d: got %h want %h",
                             p, c, snap(), want);
                end
            end
            tick();
            want = exp_w(1, 1, 0, 0, (p > 3) ? 3 : p);
            n_cmp++;
            if (snap() !== want) begin
                n_bad++;
                $display("FAIL periodic_pulse%0d: got %h want %h", p, snap(), want);
            end
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        for (int k = 0; k < 8; k++) begin
            want = exp_w(0, 0, 0, 0, 3);
            n_cmp++;
            if (snap() !== want) begin
                n_bad++;
                $display("FAIL periodic_stopped%0d: got %h want %h", k, snap(), want);
            end
            tick();
        end
    endtask

    task automatic test_abort();
        logic [12:0] want;
        kick(8'd6, 2'b00);
        repeat (5) tick();
        want = exp_w(1, 0, 0, 5, 0);
        n_cmp++;
        if (snap() !== want) begin
            n_bad++;
            $display("FAIL abort_pre: got %h want %h", snap(), want);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        for (int k = 0; k < 3; k++) begin
            want = exp_w(0, 0, 0, 0, 0);
            n_cmp++;
            if (snap() !== want) begin
                n_bad++;
                $display("FAIL abort_at_expiry%0d: got %h want %h", k, snap(), want);
            end
            tick();
        end
        stop = 1'b1;
        kick(8'd3, 2'b00);
        stop = 1'b0;
        for (int k = 0; k < 4; k++) begin
            want = exp_w(0, 0, 0, 0, 0);
            n_cmp++;
            if (snap() !== want) begin
                n_bad++;
                $display("FAIL start_stop_idle%0d: got %h want %h", k, snap(), want);
            end
            tick();
        end
        kick(8'd3, 2'b01);
        kick(8'd7, 2'b00);
        want = exp_w(1, 0, 0, 1, 0);
        n_cmp++;
        if (snap() !== want) begin
            n_bad++;
            $display("FAIL start_in_run: got %h want %h", snap(), want);
        end
        tick();
        tick();
        want = exp_w(0, 1, 0, 0, 1);
        n_cmp++;
        if (snap() !== want) begin
            n_bad++;
            $display("FAIL start_in_run_done: got %h want %h", snap(), want);
        end
        tick();
        want = exp_w(0, 0, 0, 0, 1);
        n_cmp++;
        if (snap() !== want) begin
            n_bad++;
            $display("FAIL start_in_run_after: got %h want %h", snap(), want);
        end
    endtask

    task automatic test_error();
        logic [12:0] want;
        kick(8'd0, 2'b00);
        want = exp_w(0, 0, 1, 0, 1);
        n_cmp++;
        if (snap() !== want) begin
            n_bad++;
            $display("FAIL err_idle: got %h want %h", snap(), want);
        end
        tick();
        want = exp_w(0, 0, 0, 0, 1);
        n_cmp++;
        if (snap() !== want) begin
            n_bad++;
            $display("FAIL err_idle_clear: got %h want %h", snap(), want);
        end
        kick(8'd1, 2'b00);
        tick();
        kick(8'd0, 2'b01);
        want = exp_w(0, 1, 1, 0, 1);
        n_cmp++;
        if (snap() !== want) begin
            n_bad++;
            $display("FAIL err_done: got %h want %h", snap(), want);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        want = exp_w(0, 0, 0, 0, 1);
        n_cmp++;
        if (snap() !== want) begin
            n_bad++;
            $display("FAIL err_done_stop: got %h want %h", snap(), want);
        end
    endtask

    task automatic test_latch();
        logic [12:0] want;
        kick(8'd200, 2'b01);
        load_val = 8'd5;
        mode     = 2'b10;
        repeat (199) tick();
        want = exp_w(1, 0, 0, 199, 0);
        n_cmp++;
        if (snap() !== want) begin
            n_bad++;
            $display("FAIL latch_199: got %h want %h", snap(), want);
        end
        tick();
        want = exp_w(0, 1, 0, 0, 1);
        n_cmp++;
        if (snap() !== want) begin
            n_bad++;
            $display("FAIL latch_200: got %h want %h", snap(), want);
        end
        tick();
        want = exp_w(0, 0, 0, 0, 1);
        n_cmp++;
        if (snap() !== want) begin
            n_bad++;
            $display("FAIL latch_after: got %h want %h", snap(), want);
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        rst      = 1'b1;
        start    = 1'b0;
        stop     = 1'b0;
        load_val = 8'd0;
        mode     = 2'b00;
        test_reset();
        test_level();
        test_pulse();
        test_periodic();
        test_abort();
        test_error();
        test_latch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/prog_delay_timer.md
Name: prog_delay_timer

Overview:
Programmable, parametrised delay timer. It is the successor of the fixed-constant post-reset delay block. Counts a run-time loadable number of clock cycles after a start request and signals expiry in one of three modes: held level, single pulse, or periodic pulse. Restart and abort are possible without a reset. Used as a generic timing source for sequencing, timeouts and periodic ticks inside the lab designs.

Parameters:
WIDTH, 8, width of delay load value and cycle counter (delay range 1 to 2^WIDTH-1 cycles)
EXP_W, 8, width of periodic expiry counter (saturating)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  start/restart request, sampled on clk rising edge
stop  input  1  abort request, sampled on clk rising edge
load_val  input  WIDTH  delay length N in cycles, latched when start is accepted
mode  input  2  00 LEVEL, 01 PULSE, 10 PERIODIC, 11 reserved (behaves as PULSE); latched when start is accepted
busy  output  1  high while timer is in RUN
done  output  1  expiry indication (level or pulse per mode)
err  output  1  one-cycle pulse: start was rejected because load_val == 0
count  output  WIDTH  current cycle count inside RUN, 0 otherwise
exp_cnt  output  EXP_W  number of expiries since last accepted start, saturates at 2^EXP_W-1

Behaviour:
- All outputs are registered. Asynchronous reset (rst=1) forces state IDLE, busy=0, done=0, err=0, count=0, exp_cnt=0, load_q=0, mode_q=00. Reset takes effect immediately, including mid-RUN. No expiry occurs for the aborted run.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1, stop=0, load_val!=0: latch load_q=load_val and mode_q=mode; count<=0; exp_cnt<=0; go to RUN.
  - start=1, load_val==0: stay in IDLE; err=1 for exactly one cycle.
- RUN, each edge, with stop=0:
  - If count == load_q-1, the run expires.
  - Otherwise count<=count+1.
- Latency: start accepted at edge E0. Expiry occurs at edge E_N. done is high in the cycle after E_N, i.e. N cycles after the accepting edge. N=1 gives done in the cycle after E1.
- On expiry:
  - count<=0 in all modes.
  - exp_cnt<=exp_cnt+1, saturating at the maximum value.
  - LEVEL: go to DONE; done=1 and held.
  - PULSE and reserved mode: done=1 for one cycle; go to IDLE.
  - PERIODIC: done=1 for one cycle; stay in RUN. The next expiry follows N cycles later, so done repeats every N cycles.
- DONE: done stays 1 until start or stop.
  - start with a valid load_val: restart as from IDLE; done=0 in the cycle after the edge.
  - start with load_val==0: err pulse; remain in DONE.
  - stop: done<=0; go to IDLE.
- stop in RUN: go to IDLE, count<=0, no done pulse. exp_cnt is held.
- Priorities on the same edge:
  - stop beats start.
  - stop beats expiry, so no done is generated.
- start while in RUN: ignored. No restart, no err.
- load_val and mode changes during RUN have no effect; the latched values are used.
- busy=1 exactly while state is RUN.

Test Plan:
- Reset: rst=1 asynchronously mid-cycle -> busy, done, err, count and exp_cnt go to 0 immediately. The next start runs normally.
- LEVEL: load_val=5, mode=00, start pulse at E0 -> count steps 0,1,2,3,4. done rises after E5 and stays high for 20+ cycles. start with load_val=3 -> done falls next cycle and rises again 3 cycles later.
- PULSE: load_val=1, mode=01 -> done high exactly 1 cycle, after E1. busy=0 afterwards. exp_cnt=1.
- PERIODIC with saturation: load_val=4, mode=10, EXP_W=2 -> done pulses every 4 cycles. exp_cnt goes 1,2,3,3. stop -> busy=0 and no further pulses.
- Abort and priority:
  - load_val=6, stop at the expiry edge (count=5) -> no done, IDLE.
  - start and stop together in IDLE -> no run.
  - start during RUN -> ignored, original timing preserved.
- Error and latching:
  - start with load_val=0 -> err high 1 cycle, busy stays 0.
  - load_val=200 with WIDTH=8 -> done after exactly 200 cycles, even if load_val is changed mid-run.
